// File: rtl/ac_ctrl_pkg.sv
// Shared definitions for the accumulator control sequencer:
// widths, opcode values and FSM state encoding.
package ac_ctrl_pkg;

    localparam int ADDR_W = 12;
    localparam int OPC_W  = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_LOAD = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OPC_W-1:0] OP_INC  = 4'h3;
    localparam logic [OPC_W-1:0] OP_CLR  = 4'h4;
    localparam logic [OPC_W-1:0] OP_MOVR = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h6;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'h7;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_OPRD   = 3'd3,
        ST_ALUWB  = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/ac_ctrl_seq.sv
// Instruction sequencer: fetches words over a req/ack read port, decodes the
// opcode and issues one-cycle accumulator control strobes.
module ac_ctrl_seq
    import ac_ctrl_pkg::*;
#(
    parameter int N = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N-1:0]      bus_in,
    input  logic              mem_ack,
    input  logic              ac_zero,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              write_en,
    output logic              alu_to_ac,
    output logic              ac_to_alu,
    output logic              inc_en,
    output logic              clr_en,
    output logic              ac_to_r,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   pc_r, pc_s;
    logic [N-1:0]        ir_r, ir_s;
    logic                illegal_r, illegal_s;

    logic [OPC_W-1:0]    opcode_s;
    logic [ADDR_W-1:0]   operand_s;

    assign opcode_s  = ir_r[N-1 -: OPC_W];
    assign operand_s = ir_r[ADDR_W-1:0];

    // State, program counter, instruction and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            pc_r      <= {ADDR_W{1'b0}};
            ir_r      <= {N{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            ir_r      <= ir_s;
            illegal_r <= illegal_s;
        end
    end

    // Next-state decode; operand strobes are Mealy on mem_ack so they line up with bus data
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        ir_s      = ir_r;
        illegal_s = illegal_r;
        mem_rd    = 1'b0;
        mem_addr  = pc_r;
        write_en  = 1'b0;
        alu_to_ac = 1'b0;
        ac_to_alu = 1'b0;
        inc_en    = 1'b0;
        clr_en    = 1'b0;
        ac_to_r   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_HALT: begin
                if (start) begin
                    state_s   = ST_FETCH;
                    illegal_s = 1'b0;
                end else begin
                    state_s = ST_HALT;
                end
            end

            ST_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = pc_r;
                if (mem_ack) begin
                    ir_s    = bus_in;
                    pc_s    = pc_r + 12'd1;
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end

            ST_DECODE: begin
                case (opcode_s)
                    OP_NOP:  state_s = ST_FETCH;
                    OP_INC: begin
                        inc_en  = 1'b1;
                        state_s = ST_FETCH;
                    end
                    OP_CLR: begin
                        clr_en  = 1'b1;
                        state_s = ST_FETCH;
                    end
                    OP_JMP: begin
                        pc_s    = operand_s;
                        state_s = ST_FETCH;
                    end
                    OP_JZ: begin
                        if (ac_zero) begin
                            pc_s = operand_s;
                        end else begin
                            pc_s = pc_r;
                        end
                        state_s = ST_FETCH;
                    end
                    OP_LOAD, OP_ADD, OP_MOVR: state_s = ST_OPRD;
                    OP_HALT: state_s = ST_HALT;
                    default: begin
                        illegal_s = 1'b1;
                        state_s   = ST_HALT;
                    end
                endcase
            end

            ST_OPRD: begin
                mem_rd   = 1'b1;
                mem_addr = operand_s;
                if (mem_ack) begin
                    case (opcode_s)
                        OP_LOAD: begin
                            write_en = 1'b1;
                            state_s  = ST_FETCH;
                        end
                        OP_ADD: begin
                            ac_to_alu = 1'b1;
                            state_s   = ST_ALUWB;
                        end
                        OP_MOVR: begin
                            ac_to_r = 1'b1;
                            state_s = ST_FETCH;
                        end
                        default: state_s = ST_FETCH;
                    endcase
                end else begin
                    state_s = ST_OPRD;
                end
            end

            ST_ALUWB: begin
                alu_to_ac = 1'b1;
                state_s   = ST_FETCH;
            end

            default: state_s = ST_IDLE;
        endcase
    end

    assign pc      = pc_r;
    assign illegal = illegal_r;
    assign busy    = (state_r != ST_IDLE) && (state_r != ST_HALT);
    assign halted  = (state_r == ST_HALT);

endmodule

// File: tb/tb_ac_ctrl_seq.sv
// Directed bench for ac_ctrl_seq: the bench plays memory, and a scoreboard of
// expected strobes (with their cycle and bus value) is checked by a monitor.
module tb_ac_ctrl_seq;

    localparam logic [5:0] S_WE   = 6'b100000;
    localparam logic [5:0] S_A2AC = 6'b010000;
    localparam logic [5:0] S_A2AL = 6'b001000;
    localparam logic [5:0] S_INC  = 6'b000100;
    localparam logic [5:0] S_CLR  = 6'b000010;
    localparam logic [5:0] S_A2R  = 6'b000001;

    typedef struct {
        int          cyc;
        logic [5:0]  s;
        logic [15:0] bus;
        bit          chk_bus;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bus_in = 16'hDEAD;
    logic        mem_ack = 1'b0;
    logic        ac_zero = 1'b0;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic        write_en, alu_to_ac, ac_to_alu, inc_en, clr_en, ac_to_r;
    logic [11:0] pc;
    logic        busy, halted, illegal;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];

    ac_ctrl_seq #(.N(16)) dut (
        .clk(clk), .rst(rst), .start(start), .bus_in(bus_in),
        .mem_ack(mem_ack), .ac_zero(ac_zero), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .write_en(write_en), .alu_to_ac(alu_to_ac),
        .ac_to_alu(ac_to_alu), .inc_en(inc_en), .clr_en(clr_en),
        .ac_to_r(ac_to_r), .pc(pc), .busy(busy), .halted(halted),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #2;
    endtask

    // Strobe monitor: every asserted strobe must match the head of the scoreboard
    always @(negedge clk) begin
        logic [5:0] s;
        exp_t       e;
        s = {write_en, alu_to_ac, ac_to_alu, inc_en, clr_en, ac_to_r};
        if (s !== 6'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {26'd0, s}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("strobe", {26'd0, s}, {26'd0, e.s});
                chk("strobe_cycle", cyc, e.cyc);
                if (e.chk_bus) chk("strobe_bus", {16'd0, bus_in}, {16'd0, e.bus});
            end
        end
    end

    // Serve one read: gap idle cycles, wait_n request cycles, then the ack cycle
    task automatic serve(input logic [11:0] addr, input logic [15:0] data,
                         input int gap, input int wait_n,
                         input logic [5:0] s_now, input logic [5:0] s_next);
        exp_t e;
        for (int g = 0; g < gap; g++) begin
            #1 chk("mem_rd_idle", {31'd0, mem_rd}, 32'd0);
            advance();
        end
        for (int w = 0; w < wait_n; w++) begin
            #1 chk("mem_rd_req", {31'd0, mem_rd}, 32'd1);
            chk("mem_addr_req", {20'd0, mem_addr}, {20'd0, addr});
            advance();
        end
        if (s_now != 6'b0) begin
            e.cyc = cyc; e.s = s_now; e.bus = data; e.chk_bus = 1'b1;
            sb.push_back(e);
        end
        if (s_next != 6'b0) begin
            e.cyc = cyc + 1; e.s = s_next; e.bus = 16'h0; e.chk_bus = 1'b0;
            sb.push_back(e);
        end
        mem_ack = 1'b1;
        bus_in  = data;
        #1 chk("mem_rd_ack", {31'd0, mem_rd}, 32'd1);
        chk("mem_addr_ack", {20'd0, mem_addr}, {20'd0, addr});
        advance();
        mem_ack = 1'b0;
        bus_in  = 16'hDEAD;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        advance();
        advance();
        rst = 1'b0;
        #1 chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_pc", {20'd0, pc}, 32'd0);

        // Reset mid-fetch with an ack pending, then a late ack in IDLE
        advance();
        start = 1'b1;
        advance();
        start = 1'b0;
        #1 chk("midrst_fetch_rd", {31'd0, mem_rd}, 32'd1);
        rst = 1'b1; mem_ack = 1'b1; bus_in = 16'h4000;
        advance();
        rst = 1'b0; mem_ack = 1'b0; bus_in = 16'hDEAD;
        #1 chk("midrst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_pc", {20'd0, pc}, 32'd0);
        mem_ack = 1'b1; bus_in = 16'h3000;
        advance();
        mem_ack = 1'b0; bus_in = 16'hDEAD;
        #1 chk("late_ack_ir", {16'd0, dut.ir_r}, 32'd0);
        chk("late_ack_pc", {20'd0, pc}, 32'd0);
        chk("late_ack_busy", {31'd0, busy}, 32'd0);

        // Program: LOAD 0x010, ADD 0x011, HALT
        advance();
        start = 1'b1;
        advance();
        start = 1'b0;
        serve(12'h000, 16'h1010, 0, 1, 6'b0, 6'b0);
        serve(12'h010, 16'h0005, 1, 1, S_WE, 6'b0);
        serve(12'h001, 16'h2011, 0, 1, 6'b0, 6'b0);
        serve(12'h011, 16'h0007, 1, 1, S_A2AL, S_A2AC);
        serve(12'h002, 16'hF000, 1, 1, 6'b0, 6'b0);
        advance();
        #1 chk("prog_halted", {31'd0, halted}, 32'd1);
        chk("prog_pc", {20'd0, pc}, 32'd3);
        chk("prog_busy", {31'd0, busy}, 32'd0);
        chk("prog_illegal", {31'd0, illegal}, 32'd0);

        // JZ taken then not taken; start held high while busy is ignored
        start = 1'b1;
        advance();
        serve(12'h003, 16'h0000, 0, 1, 6'b0, 6'b0);
        ac_zero = 1'b1;
        serve(12'h004, 16'h7020, 1, 1, 6'b0, 6'b0);
        advance();
        ac_zero = 1'b0;
        start = 1'b0;
        #1 chk("jz_taken_pc", {20'd0, pc}, 32'h020);
        serve(12'h020, 16'h7030, 0, 1, 6'b0, 6'b0);
        advance();
        #1 chk("jz_not_taken_pc", {20'd0, pc}, 32'h021);

        // JMP to the last address, NOP there, pc wraps to 0
        serve(12'h021, 16'h6FFF, 0, 1, 6'b0, 6'b0);
        advance();
        #1 chk("jmp_pc", {20'd0, pc}, 32'hFFF);
        serve(12'hFFF, 16'h0000, 0, 1, 6'b0, 6'b0);
        #1 chk("wrap_pc", {20'd0, pc}, 32'h000);

        // Illegal opcode 9 halts with sticky flag
        serve(12'h000, 16'h9000, 1, 1, 6'b0, 6'b0);
        advance();
        #1 chk("illegal_flag", {31'd0, illegal}, 32'd1);
        chk("illegal_halted", {31'd0, halted}, 32'd1);
        chk("illegal_pc", {20'd0, pc}, 32'd1);
        start = 1'b1;
        advance();
        start = 1'b0;
        #1 chk("illegal_cleared", {31'd0, illegal}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);

        // INC, CLR, LOAD with 4 wait cycles, MOVR, HALT
        serve(12'h001, 16'h3000, 0, 1, 6'b0, S_INC);
        serve(12'h002, 16'h4000, 1, 1, 6'b0, S_CLR);
        serve(12'h003, 16'h1040, 1, 1, 6'b0, 6'b0);
        serve(12'h040, 16'h1234, 1, 4, S_WE, 6'b0);
        serve(12'h004, 16'h5041, 0, 1, 6'b0, 6'b0);
        serve(12'h041, 16'hBEEF, 1, 1, S_A2R, 6'b0);
        serve(12'h005, 16'hF000, 0, 1, 6'b0, 6'b0);
        advance();
        #1 chk("final_halted", {31'd0, halted}, 32'd1);
        chk("final_pc", {20'd0, pc}, 32'd6);
        advance();
        advance();
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
